// File: rtl/multiplekser_wejsc.sv
// ---------------------------------------------------------------------------
// multiplekser_wejsc
//
// Input-side multiplexer for the PLC input terminals. Each of the eight 8-bit
// raw ports is brought into the clock domain through a two-flop synchroniser.
// It is then debounced as a whole word, and rising edges of the accepted word
// are latched per bit. A one-cycle read strobe returns the debounced word and
// the edge flags of one port onto the CPU data bus. The edge flags of that
// port are cleared by the read.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive cycles a synchronised word must stay
//                     unchanged before it is accepted. Must be 2 or more.
//
// Ports
//   clk          : system clock, rising edge active
//   rst_n        : asynchronous active-low reset
//   in0 .. in7   : raw asynchronous 8-bit input ports
//   sel          : port index, sampled only while odczyt = 1
//   odczyt       : read strobe, one cycle per read, back-to-back allowed
//   out          : debounced word of the last port read
//   zbocza       : rising-edge flags of the last port read
//   gotowe       : one-cycle pulse, out/zbocza valid
// ---------------------------------------------------------------------------
module multiplekser_wejsc #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic [7:0] in4,
   input  logic [7:0] in5,
   input  logic [7:0] in6,
   input  logic [7:0] in7,
   input  logic [2:0] sel,
   input  logic       odczyt,
   output logic [7:0] out,
   output logic [7:0] zbocza,
   output logic       gotowe
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [7:0]    raw_s  [8];

   logic [7:0]    s1_q   [8];
   logic [7:0]    s2_q   [8];
   logic [7:0]    p_q    [8];
   logic [CW-1:0] cnt_q  [8];
   logic [CW-1:0] cnt_d  [8];
   logic [7:0]    st_q   [8];
   logic [7:0]    st_d   [8];
   logic [7:0]    ef_q   [8];
   logic [7:0]    ef_d   [8];

   logic [7:0]    out_q;
   logic [7:0]    out_d;
   logic [7:0]    zbocza_q;
   logic [7:0]    zbocza_d;
   logic          gotowe_q;
   logic          gotowe_d;

   assign raw_s[0] = in0;
   assign raw_s[1] = in1;
   assign raw_s[2] = in2;
   assign raw_s[3] = in3;
   assign raw_s[4] = in4;
   assign raw_s[5] = in5;
   assign raw_s[6] = in6;
   assign raw_s[7] = in7;

   // Debounce counters, stable-word update and edge-flag set/clear per port.
   always_comb begin
      cnt_d = cnt_q;
      st_d  = st_q;
      ef_d  = ef_q;
      for (int k = 0; k < 8; k++) begin
         logic       accept_s;
         logic [7:0] rise_s;
         logic       rd_s;
         if (s2_q[k] != p_q[k]) begin
            cnt_d[k] = '0;
         end else if (cnt_q[k] == CNT_MAX) begin
            cnt_d[k] = CNT_MAX;
         end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
         end
         // Accepting on the next count value means a word that reaches s2 at
         // edge 1 is accepted at edge 1+DEBOUNCE_CYCLES.
         accept_s = (s2_q[k] == p_q[k]) && (cnt_d[k] == CNT_MAX);
         if (accept_s) begin
            st_d[k] = s2_q[k];
            rise_s  = s2_q[k] & ~st_q[k];
         end else begin
            st_d[k] = st_q[k];
            rise_s  = 8'h00;
         end
         // A read clears the flags, but edges found in the same cycle are
         // still set, so no edge is lost.
         rd_s    = odczyt && (sel == 3'(k));
         ef_d[k] = (rd_s ? 8'h00 : ef_q[k]) | rise_s;
      end
   end

   // Read port: capture the selected port on a strobe and hold it otherwise.
   always_comb begin
      out_d    = out_q;
      zbocza_d = zbocza_q;
      gotowe_d = odczyt;
      if (odczyt) begin
         out_d    = st_q[sel];
         zbocza_d = ef_q[sel];
      end else begin
         out_d    = out_q;
         zbocza_d = zbocza_q;
      end
   end

   // State registers: synchroniser, debounce state, edge flags and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= '{default: 8'h00};
         s2_q     <= '{default: 8'h00};
         p_q      <= '{default: 8'h00};
         cnt_q    <= '{default: '0};
         st_q     <= '{default: 8'h00};
         ef_q     <= '{default: 8'h00};
         out_q    <= 8'h00;
         zbocza_q <= 8'h00;
         gotowe_q <= 1'b0;
      end else begin
         s1_q     <= raw_s;
         s2_q     <= s1_q;
         p_q      <= s2_q;
         cnt_q    <= cnt_d;
         st_q     <= st_d;
         ef_q     <= ef_d;
         out_q    <= out_d;
         zbocza_q <= zbocza_d;
         gotowe_q <= gotowe_d;
      end
   end

   assign out    = out_q;
   assign zbocza = zbocza_q;
   assign gotowe = gotowe_q;

endmodule

// File: tb/tb_multiplekser_wejsc.sv
// ---------------------------------------------------------------------------
// tb_multiplekser_wejsc
//
// Directed bench for multiplekser_wejsc with DEBOUNCE_CYCLES = 4. Inputs are
// driven 1 ns after a rising edge. Outputs are sampled at the same point,
// after the edge under test.
// ---------------------------------------------------------------------------
module tb_multiplekser_wejsc;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] in0 = 8'h00;
   logic [7:0] in1 = 8'h00;
   logic [7:0] in2 = 8'h00;
   logic [7:0] in3 = 8'h00;
   logic [7:0] in4 = 8'h00;
   logic [7:0] in5 = 8'h00;
   logic [7:0] in6 = 8'h00;
   logic [7:0] in7 = 8'h00;
   logic [2:0] sel = 3'd0;
   logic       odczyt = 1'b0;
   logic [7:0] out;
   logic [7:0] zbocza;
   logic       gotowe;

   int total = 0;
   int bad   = 0;

   multiplekser_wejsc #(.DEBOUNCE_CYCLES(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .in0    (in0),
      .in1    (in1),
      .in2    (in2),
      .in3    (in3),
      .in4    (in4),
      .in5    (in5),
      .in6    (in6),
      .in7    (in7),
      .sel    (sel),
      .odczyt (odczyt),
      .out    (out),
      .zbocza (zbocza),
      .gotowe (gotowe)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   initial begin
      // Reset from time zero, with port 3 and port 5 already driven.
      in3 = 8'hA5;
      in5 = 8'h01;
      #1 rst_n = 1'b0;
      #2;
      check("rst_out", out, 8'h00);
      check("rst_zbocza", zbocza, 8'h00);
      check("rst_gotowe", {7'd0, gotowe}, 8'h00);
      #9 rst_n = 1'b1;           // released at t=12, before the edge at t=15
      tick(10);

      // Basic read of port 3: power-on edge is reported.
      odczyt = 1'b1; sel = 3'd3;
      tick(1);
      check("rd3_out", out, 8'hA5);
      check("rd3_zbocza", zbocza, 8'hA5);
      check("rd3_gotowe", {7'd0, gotowe}, 8'h01);
      odczyt = 1'b0;
      tick(1);
      check("rd3_gotowe_drop", {7'd0, gotowe}, 8'h00);
      check("rd3_out_hold", out, 8'hA5);
      check("rd3_zbocza_hold", zbocza, 8'hA5);
      odczyt = 1'b1;
      tick(1);
      check("rd3_again_zbocza", zbocza, 8'h00);
      check("rd3_again_out", out, 8'hA5);
      odczyt = 1'b0;
      tick(1);

      // Glitch of 3 cycles on port 0 is rejected.
      in0 = 8'hFF;
      tick(3);
      in0 = 8'h00;
      tick(10);
      odczyt = 1'b1; sel = 3'd0;
      tick(1);
      check("glitch3_out", out, 8'h00);
      check("glitch3_zbocza", zbocza, 8'h00);
      odczyt = 1'b0;

      // A 5-cycle pulse is accepted; the later fall is not flagged.
      in0 = 8'hFF;
      tick(5);
      in0 = 8'h00;
      tick(10);
      odczyt = 1'b1; sel = 3'd0;
      tick(1);
      check("pulse5_out", out, 8'h00);
      check("pulse5_zbocza", zbocza, 8'hFF);
      odczyt = 1'b0;
      tick(1);

      // Collision: the read of port 5 lands on the edge where st goes 01->03.
      in5 = 8'h03;
      tick(5);                   // edges 0..4 after the change
      odczyt = 1'b1; sel = 3'd5;
      tick(1);                   // edge 5: st update and read together
      check("coll_out", out, 8'h01);
      check("coll_zbocza", zbocza, 8'h01);
      tick(1);
      check("coll_next_out", out, 8'h03);
      check("coll_next_zbocza", zbocza, 8'h02);
      odczyt = 1'b0;
      tick(1);

      // Back-to-back reads of ports 1, 2 and 7.
      in1 = 8'h11; in2 = 8'h22; in7 = 8'h77;
      tick(10);
      odczyt = 1'b1; sel = 3'd1;
      tick(1);
      check("b2b_out1", out, 8'h11);
      check("b2b_gotowe1", {7'd0, gotowe}, 8'h01);
      sel = 3'd2;
      tick(1);
      check("b2b_out2", out, 8'h22);
      check("b2b_gotowe2", {7'd0, gotowe}, 8'h01);
      sel = 3'd7;
      tick(1);
      check("b2b_out7", out, 8'h77);
      check("b2b_zbocza7", zbocza, 8'h77);
      check("b2b_gotowe7", {7'd0, gotowe}, 8'h01);
      odczyt = 1'b0;
      tick(1);
      check("b2b_gotowe_drop", {7'd0, gotowe}, 8'h00);

      // Reset two cycles into the debounce of port 6.
      in6 = 8'h0F;
      tick(2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", out, 8'h00);
      check("mid_rst_zbocza", zbocza, 8'h00);
      check("mid_rst_gotowe", {7'd0, gotowe}, 8'h00);
      #1 rst_n = 1'b1;           // released well before the next edge
      odczyt = 1'b1; sel = 3'd6;
      tick(1);                   // first edge after release
      check("post_rst_out", out, 8'h00);
      check("post_rst_zbocza", zbocza, 8'h00);
      odczyt = 1'b0;
      tick(4);                   // edges 2..5 after release
      odczyt = 1'b1;
      tick(1);                   // edge 6: st[6] updates here, read sees old
      check("post_rst_e6_out", out, 8'h00);
      tick(1);                   // edge 7: new value visible
      check("post_rst_e7_out", out, 8'h0F);
      check("post_rst_e7_zbocza", zbocza, 8'h0F);
      odczyt = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multiplekser_wejsc.md
# multiplekser_wejsc

Input-side counterpart of the PLC output demultiplexer. It samples eight 8-bit physical input ports, synchronises and debounces each one, and latches rising edges per bit. A CPU read strobe then returns one selected port onto the 8-bit data bus. The block sits between the PLC input terminals and the processor's I/O read path.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive cycles a synchronised port word must stay unchanged before it is accepted. Legal values are ≥ 2.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in0` … `in7`  in  8 each  raw asynchronous input ports.
- `sel`  in  3  port index for a read; sampled only when `odczyt`=1.
- `odczyt`  in  1  read strobe, one cycle per read; back-to-back reads are allowed.
- `out`  out  8  debounced value of the selected port.
- `zbocza`  out  8  rising-edge flags of the selected port, read-to-clear.
- `gotowe`  out  1  one-cycle pulse marking `out`/`zbocza` valid.

## Operation
- **Synchroniser:** each port passes through two flops (`s1`, `s2`), 8 bits per port.
- **Debounce, per port, word-level:**
  - Each port has a counter of width $clog2(DEBOUNCE_CYCLES), plus a previous-word register `p` that is loaded from `s2` every cycle.
  - If `s2` ≠ `p`, the counter clears to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - On a cycle where the counter equals DEBOUNCE_CYCLES-1 and `s2` = `p`, the stable word `st` ← `s2`.
  - Any change inside the window restarts the count. Glitches shorter than the window never reach `st`.
- **Edge flags:** per port, `ef[k]` ← `ef[k] | (new_st & ~old_st)` whenever `st` updates. Falling edges are ignored.
- **Read:** when `odczyt`=1 at edge N, with port k = `sel`:
  - `out` ← `st[k]`, `zbocza` ← `ef[k]`, `gotowe` ← 1.
  - `ef[k]` is cleared in the same edge.
- **Set/clear collision:** if a rising edge on port k is detected in the same cycle that `ef[k]` is read:
  - `zbocza` returns the pre-update flags.
  - `ef[k]` is then left holding only the newly detected edge bits. Set wins, so no edge is lost.
- **Holding behaviour:** `out` and `zbocza` hold their last read values until the next read. `gotowe` returns to 0 on the next cycle unless `odczyt` is high again.
- **Independence of ports:** reading port k does not affect any other port's `ef`, counter or `st`.
- **Out-of-range `sel`:** not possible, since `sel` is 3 bits and every value maps to a port.
- **Reset (`rst_n`=0):** clears all `s1`, `s2`, `p`, counters, `st`, `ef`, and the outputs `out`=0, `zbocza`=0, `gotowe`=0. This applies immediately, including mid-debounce and mid-read.
  - After release, ports whose inputs are held high settle to `st`=1 through the normal debounce path. This sets `ef` bits, i.e. a post-reset "power-on edge" is reported.

## Timing
- A raw change sampled at edge 0 appears in `s2` at edge 1.
- If the input is stable, `st` updates at edge 1+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=4, that is edge 5.
- `ef` updates in the same edge as `st`.
- **Read latency:** 1 cycle. `odczyt` at edge N gives `out`/`zbocza`/`gotowe` valid after edge N.
- **Throughput:** one read per cycle.
- A read in the same edge as an `st` update returns the old `st`. The new value is visible from the next read.
- `sel` and `odczyt` are synchronous and need no synchroniser. `in0`–`in7` may change at any time.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-simulation with inputs active → `out`=0x00, `zbocza`=0x00, `gotowe`=0 immediately. A read right after release returns 0x00.
- **Basic read (DEBOUNCE_CYCLES=4):**
  - Stimulus: `in3`=0xA5 from reset, then `odczyt`=1 with `sel`=3 after 10 cycles.
  - Response: `out`=0xA5, `zbocza`=0xA5, `gotowe` pulses for exactly 1 cycle.
  - A repeat read returns `zbocza`=0x00.
- **Glitch rejection (DEBOUNCE_CYCLES=4):**
  - Stimulus: `in0` 0x00→0xFF for 3 cycles, then back to 0x00.
  - Response: a read of port 0 gives `out`=0x00, `zbocza`=0x00.
  - A 5-cycle pulse instead yields `zbocza`=0xFF.
- **Set/clear collision:**
  - Stimulus: schedule `odczyt` on port 5 in the exact cycle `st[5]` changes 0x01→0x03, with `ef[5]`=0x01 beforehand.
  - Response: read returns `out`=0x01, `zbocza`=0x01. The next read returns `out`=0x03, `zbocza`=0x02.
- **Back-to-back reads:**
  - Stimulus: `odczyt` high for 3 cycles with `sel`=1,2,7 and stable `in1`=0x11, `in2`=0x22, `in7`=0x77.
  - Response: `out` sequence 0x11, 0x22, 0x77 on consecutive cycles, with `gotowe` held high for 3 cycles.
- **Reset mid-debounce:** `in6` changes to 0x0F, and `rst_n` pulses low 2 cycles later → after release, `st[6]` reaches 0x0F only a full DEBOUNCE_CYCLES+1 edges after release.
